// File: rtl/bram_stream_reader.sv
// Sweeps a wrapping BRAM address range on command and streams the returned words
// through a small output FIFO with valid/ready/last handshaking.
//
// state | meaning
// IDLE  | waiting for start; len=0 gives an immediate done pulse
// ISSUE | issuing reads while words remain and FIFO credit allows
// DRAIN | all reads issued; waiting for the last word to be popped
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]         DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  s1_valid;
  logic                  s1_last;
  logic                  s2_valid;
  logic                  s2_last;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic        push;
  logic        pop;
  logic        last_pop;
  logic [CW:0] occupancy;
  logic        can_issue;

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];

  assign push     = s2_valid;
  assign pop      = out_valid & out_ready;
  assign last_pop = pop & fifo_last[rd_ptr];

  // Credit counts reads still in the BRAM pipeline so every issue has a slot on arrival.
  always_comb begin
    occupancy = {1'b0, fifo_count}
              + {{CW{1'b0}}, s1_valid}
              + {{CW{1'b0}}, s2_valid};
    can_issue = (state == ISSUE) && (remaining != '0) && (occupancy < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_raddr <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
    end else begin
      done     <= 1'b0;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= ISSUE;
              busy      <= 1'b1;
              addr      <= base_addr;
              remaining <= len;
            end
          end
        end
        ISSUE: begin
          if (can_issue) begin
            bram_raddr <= addr;
            addr       <= addr + 1'b1;
            remaining  <= remaining - 1'b1;
            s1_valid   <= 1'b1;
            if (remaining == REM_ONE) begin
              s1_last <= 1'b1;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bram_rdata;
        fifo_last[wr_ptr] <= s2_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: a behavioural BRAM plus a queue-based
// model of the expected word sequence for each transfer.
module tb_bram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] len = '0;
  logic       busy;
  logic       done;
  logic [3:0] bram_raddr;
  logic [7:0] bram_rdata = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16];

  bram_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Registered read port, one cycle latency, no enable.
  always @(posedge clk) bram_rdata <= mem[bram_raddr];

  // Observations gathered by run_xfer; each test judges them.
  logic [7:0] rx_data [$];
  bit         rx_last [$];
  logic [7:0] exp_q [$];
  int first_valid_k, done_k, busy_low_k, last_pop_k, done_count;
  int stall_err, overflow;
  bit busy_seen, valid_seen, timed_out, reset_hit;
  logic snap_busy, snap_done, snap_valid, snap_last;
  logic [3:0] snap_raddr;
  logic [7:0] snap_data;
  logic [3:0] last_raddr_exp = '0;

  function automatic void model_words(input logic [3:0] b, input logic [4:0] n);
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(b) + i) % 16]);
  endfunction

  task automatic run_xfer(input logic [3:0] b, input logic [4:0] n, input int ready_pct,
                          input int restart_k, input logic [3:0] restart_base, input int reset_words);
    bit r, prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;
    rx_data.delete(); rx_last.delete();
    first_valid_k = -1; done_k = -1; busy_low_k = -1; last_pop_k = -1; done_count = 0;
    stall_err = 0; overflow = 0; busy_seen = 0; valid_seen = 0; timed_out = 0; reset_hit = 0;
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = n;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (reset_words >= 0 && rx_data.size() == reset_words) begin
        rst_n = 1'b0;
        #1;
        snap_busy = busy; snap_done = done; snap_valid = out_valid;
        snap_last = out_last; snap_raddr = bram_raddr; snap_data = out_data;
        reset_hit = 1;
        start = 1'b0; out_ready = 1'b0;
        break;
      end
      start = (k == restart_k);
      base_addr = start ? restart_base : 4'($urandom);
      len = start ? 5'd5 : 5'($urandom);
      if (busy) busy_seen = 1;
      if (!busy && busy_low_k < 0) busy_low_k = k;
      if (out_valid) valid_seen = 1;
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (done) begin
        done_count++;
        if (done_k < 0) done_k = k;
      end
      if (prev_valid && !prev_ready &&
          (!out_valid || out_data !== prev_data || out_last !== prev_last)) stall_err++;
      if (dut.fifo_count > 4) overflow++;
      r = ($urandom_range(99) < ready_pct);
      out_ready = r;
      if (out_valid && r) begin
        rx_data.push_back(out_data);
        rx_last.push_back(out_last);
        if (out_last) last_pop_k = k;
      end
      prev_valid = out_valid; prev_ready = r; prev_data = out_data; prev_last = out_last;
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    start = 1'b0;
    timed_out = (done_k < 0) && !reset_hit;
    if (n != 0 && !reset_hit) last_raddr_exp = 4'((int'(b) + int'(n) - 1) % 16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || out_valid !== 0 || out_last !== 0 ||
        bram_raddr !== 4'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b valid=%b last=%b raddr=%h data=%h want all zero",
               busy, done, out_valid, out_last, bram_raddr, out_data);
    end
    rst_n = 1'b1;
    last_raddr_exp = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    model_words(4'd3, 5'd8);
    run_xfer(4'd3, 5'd8, 100, -1, 4'd0, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++;
    if (rx_data.size() != 8) begin
      errors++; $display("FAIL basic_count got %0d want 8", rx_data.size());
    end
    for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL basic_word[%0d] got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_q[i], i == 7);
      end
    end
    checks++;
    if (first_valid_k != 3) begin
      errors++; $display("FAIL basic_latency got %0d want 3", first_valid_k);
    end
    checks++;
    if (last_pop_k - first_valid_k != 7) begin
      errors++; $display("FAIL basic_throughput got span %0d want 7", last_pop_k - first_valid_k);
    end
    checks++;
    if (done_k != last_pop_k + 1 || done_count != 1) begin
      errors++; $display("FAIL basic_done got k=%0d n=%0d want k=%0d n=1", done_k, done_count, last_pop_k + 1);
    end
    checks++;
    if (busy_low_k != 11) begin
      errors++; $display("FAIL basic_busy_low got %0d want 11", busy_low_k);
    end
    checks++;
    if (bram_raddr !== last_raddr_exp) begin
      errors++; $display("FAIL basic_raddr_hold got %h want %h", bram_raddr, last_raddr_exp);
    end
  endtask

  task automatic test_wrap();
    model_words(4'd14, 5'd4);
    run_xfer(4'd14, 5'd4, 100, -1, 4'd0, -1);
    checks++;
    if (rx_data.size() != 4 || timed_out) begin
      errors++; $display("FAIL wrap_count got %0d timeout=%b want 4", rx_data.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL wrap_word[%0d] got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_q[i], i == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    model_words(4'd0, 5'd16);
    run_xfer(4'd0, 5'd16, 50, -1, 4'd0, -1);
    checks++;
    if (rx_data.size() != 16 || timed_out) begin
      errors++; $display("FAIL bp_count got %0d timeout=%b want 16", rx_data.size(), timed_out);
    end
    for (int i = 0; i < 16 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL bp_word[%0d] got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_q[i], i == 15);
      end
    end
    checks++;
    if (stall_err != 0 || overflow != 0 || done_count != 1) begin
      errors++;
      $display("FAIL bp_stability got stall=%0d ovf=%0d done=%0d want 0/0/1", stall_err, overflow, done_count);
    end
  endtask

  task automatic test_zero_len();
    run_xfer(4'd9, 5'd0, 100, -1, 4'd0, -1);
    checks++;
    if (done_k != 0 || done_count != 1) begin
      errors++; $display("FAIL zero_done got k=%0d n=%0d want k=0 n=1", done_k, done_count);
    end
    checks++;
    if (busy_seen || valid_seen || rx_data.size() != 0) begin
      errors++;
      $display("FAIL zero_quiet got busy=%b valid=%b words=%0d want 0/0/0", busy_seen, valid_seen, rx_data.size());
    end
    checks++;
    if (bram_raddr !== last_raddr_exp) begin
      errors++; $display("FAIL zero_raddr got %h want %h", bram_raddr, last_raddr_exp);
    end
  endtask

  task automatic test_start_while_busy();
    model_words(4'd2, 5'd8);
    run_xfer(4'd2, 5'd8, 100, 4, 4'd12, -1);
    checks++;
    if (rx_data.size() != 8 || done_count != 1 || timed_out) begin
      errors++;
      $display("FAIL busy_start_count got %0d done=%0d want 8 done=1", rx_data.size(), done_count);
    end
    for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL busy_start_word[%0d] got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_q[i], i == 7);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_xfer(4'd0, 5'd12, 100, -1, 4'd0, 3);
    checks++;
    if (!reset_hit || snap_busy !== 0 || snap_done !== 0 || snap_valid !== 0 ||
        snap_last !== 0 || snap_raddr !== 4'd0 || snap_data !== 8'd0) begin
      errors++;
      $display("FAIL midreset_values got hit=%b busy=%b done=%b valid=%b last=%b raddr=%h data=%h want zeros",
               reset_hit, snap_busy, snap_done, snap_valid, snap_last, snap_raddr, snap_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_raddr_exp = '0;
    model_words(4'd5, 5'd2);
    run_xfer(4'd5, 5'd2, 100, -1, 4'd0, -1);
    checks++;
    if (rx_data.size() != 2 || done_count != 1) begin
      errors++; $display("FAIL midreset_count got %0d done=%0d want 2 done=1", rx_data.size(), done_count);
    end
    for (int i = 0; i < 2 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL midreset_word[%0d] got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_q[i], i == 1);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic [4:0] n;
    int pct;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      b = 4'($urandom);
      n = (t == 0) ? 5'd16 : 5'($urandom_range(16, 1));
      pct = (t % 3 == 0) ? 30 : ((t % 3 == 1) ? 70 : 100);
      model_words(b, n);
      run_xfer(b, n, pct, -1, 4'd0, -1);
      checks++;
      if (rx_data.size() != int'(n) || done_count != 1 || stall_err != 0 || overflow != 0) begin
        errors++;
        $display("FAIL rand%0d_summary got words=%0d done=%0d stall=%0d ovf=%0d want %0d/1/0/0",
                 t, rx_data.size(), done_count, stall_err, overflow, n);
      end
      for (int i = 0; i < int'(n) && i < rx_data.size(); i++) begin
        checks++;
        if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == int'(n) - 1)) begin
          errors++;
          $display("FAIL rand%0d_word[%0d] got %h/%b want %h/%b", t, i, rx_data[i], rx_last[i],
                   exp_q[i], i == int'(n) - 1);
        end
      end
      checks++;
      if (bram_raddr !== last_raddr_exp) begin
        errors++; $display("FAIL rand%0d_raddr got %h want %h", t, bram_raddr, last_raddr_exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for the team's simple dual-port BRAM. That BRAM has a registered read port with 1-cycle latency and no read enable.
- On a start command the block sweeps a contiguous, wrapping address range. It drives the BRAM read address and captures the returned words into a small output FIFO.
- Captured words are presented on a valid/ready stream with a last flag, so the consumer may apply backpressure.
- Sits between a BRAM written by an upstream producer and any downstream streaming consumer.

Parameters:
- ADDR_WIDTH, 4, BRAM address width; addresses wrap modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=4 for full throughput.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only while busy=0.
- base_addr  in  ADDR_WIDTH  first address; captured with start.
- len  in  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH; captured with start.
- busy  out  1  high from the edge start is accepted until the transfer completes.
- done  out  1  one-cycle completion pulse.
- bram_raddr  out  ADDR_WIDTH  registered BRAM read address.
- bram_rdata  in  DATA_WIDTH  BRAM read data; corresponds to the bram_raddr present in the previous cycle.
- out_data  out  DATA_WIDTH  stream data (head of FIFO).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of the transfer; qualified by out_valid.

Behaviour:
- Reset (rst_n low, async): busy, done, out_valid, out_last = 0; bram_raddr = 0; out_data = 0. FIFO is emptied, pipeline valids are cleared, state = IDLE.
- Reset mid-transfer: in-flight words are discarded, no done pulse is produced, and the block restarts in IDLE.
- States:
  - IDLE: start=1 with len>0 -> ISSUE. Captures addr=base_addr and remaining=len; busy=1 from the next cycle.
  - IDLE with start=1 and len=0: stays IDLE. done=1 for exactly the next cycle, busy stays 0, no read is issued.
  - ISSUE: a read is issued in a cycle when remaining>0 and (fifo_count + inflight) < FIFO_DEPTH. fifo_count is the pre-pop occupancy; inflight is 0..2. On issue, at the edge: bram_raddr<=addr, addr<=addr+1 (wraps), remaining<=remaining-1, pipeline stage1 valid set. When the final read is issued (remaining becomes 0) -> DRAIN.
  - DRAIN: wait until the last word has been handshaken -> IDLE.
- Read pipeline: stage1 valid moves to stage2 on the next edge, because the BRAM samples bram_raddr at that edge. On the following edge bram_rdata is written into the FIFO, with a last tag if it was the final issued address. No issue is ever dropped: the credit rule guarantees FIFO space on arrival.
- Latency: with start accepted at edge E0, bram_raddr=base after E1, bram_rdata is valid after E2, and out_valid=1 after E3.
- Throughput: with out_ready held 1 and FIFO_DEPTH>=4, one word per cycle, no bubbles.
- Stream:
  - out_valid = FIFO non-empty. out_data and out_last come from the FIFO head.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
  - Pop on out_valid & out_ready. Simultaneous push and pop in one cycle is supported and leaves the count unchanged.
- Completion: on the edge that pops the word tagged last, done=1 for one cycle and busy=0 from the following cycle. A new start may be sampled in the first cycle busy=0.
- start while busy=1 is ignored; base_addr and len changes are ignored while busy.
- len=2**ADDR_WIDTH reads every address exactly once, starting at base_addr.
- bram_raddr holds its last value when no read is being issued.

Test Plan:
- Basic read: preload mem[i]=i+0x10, base=3, len=8, out_ready=1. Expect 0x13..0x1A on 8 consecutive cycles, first out_valid 3 cycles after start, out_last on 0x1A, done one cycle later, busy then low.
- Wrap-around: ADDR_WIDTH=4, base=14, len=4. Expect data from addresses 14,15,0,1 in order, with out_last on address 1.
- Backpressure: base=0, len=16, out_ready pseudo-random at 50%. Expect all 16 words in order, no loss or duplication, data stable while stalled, FIFO never overflows (check fifo_count<=FIFO_DEPTH).
- Zero length: start with len=0. Expect done pulse the next cycle, busy never high, out_valid never high, bram_raddr unchanged.
- Start while busy: second start pulse mid-transfer with a different base. Expect it ignored and the original 8-word sequence unaltered.
- Reset mid-op: assert rst_n=0 after 3 words. Expect outputs at reset values immediately; then a fresh start base=5, len=2 yields exactly mem[5], mem[6] with no stale words.
